// File: rtl/fhn_stim_sequencer_if.sv
// fhn_stim_sequencer_if: configuration, control, voltage and stimulus signals of the stimulus sequencer
// master drives table writes, start/abort/loop_en and v_in; slave (the sequencer) drives i_out and status
interface fhn_stim_sequencer_if #(
  parameter int DATA_W     = 16,
  parameter int NUM_PHASES = 8,
  parameter int DUR_W      = 16,
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 12
);
  localparam int AW = $clog2(NUM_PHASES);
  logic                     cfg_we;
  logic [AW-1:0]            cfg_addr;
  logic [DATA_W-1:0]        cfg_amp;
  logic [DUR_W-1:0]         cfg_dur;
  logic [DATA_W-1:0]        cfg_step;
  logic                     start;
  logic                     abort;
  logic                     loop_en;
  logic [NUM_CH*DATA_W-1:0] v_in;
  logic [DATA_W-1:0]        i_out;
  logic [AW-1:0]            phase_idx;
  logic                     busy;
  logic                     phase_end;
  logic                     done;
  logic [NUM_CH*CNT_W-1:0]  spike_cnt;
  modport master (
    output cfg_we, cfg_addr, cfg_amp, cfg_dur, cfg_step, start, abort, loop_en, v_in,
    input  i_out, phase_idx, busy, phase_end, done, spike_cnt
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_amp, cfg_dur, cfg_step, start, abort, loop_en, v_in,
    output i_out, phase_idx, busy, phase_end, done, spike_cnt
  );
endinterface

// File: rtl/fhn_stim_sequencer.sv
// fhn_stim_sequencer: phase-table driven step/ramp stimulus generator with per-channel spike counters
// ports: clk, rst (async, active high), bus (slave) carrying table writes, start/abort/loop_en,
// channel voltages v_in, and outputs i_out, phase_idx, busy, phase_end, done, spike_cnt
module fhn_stim_sequencer #(
  parameter int DATA_W     = 16,
  parameter int FRC_BITS   = 12,
  parameter int NUM_PHASES = 8,
  parameter int DUR_W      = 16,
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 12,
  parameter int SPK_THRESH = 2048,
  parameter int SPK_HYST   = 1024
) (
  input logic clk,
  input logic rst,
  fhn_stim_sequencer_if.slave bus
);
  localparam int AW = $clog2(NUM_PHASES);
  localparam logic signed [DATA_W-1:0] TH = DATA_W'(SPK_THRESH);
  localparam logic signed [DATA_W-1:0] RE = DATA_W'(SPK_THRESH - SPK_HYST);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic signed [DATA_W-1:0] amp_t [NUM_PHASES];
  logic [DUR_W-1:0] dur_t [NUM_PHASES];
  logic [DATA_W-1:0] step_t [NUM_PHASES];
  logic [AW-1:0] idx, idx_n, idx_inc;
  logic [DUR_W-1:0] rem, rem_n;
  logic signed [DATA_W-1:0] i_q, i_n, i_ramp;
  logic signed [DATA_W:0] diff, mag, stp;
  logic last, prog_end, clr;
  logic [NUM_CH-1:0] armed, armed_n;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] cnt_n [NUM_CH];
  logic signed [DATA_W-1:0] v_q [NUM_CH];
  always_comb begin
    state_n = state;
    idx_n = idx;
    rem_n = rem;
    clr = 1'b0;
    last = state == RUN && rem == DUR_W'(1);
    idx_inc = idx + AW'(1);
    prog_end = idx == AW'(NUM_PHASES - 1) || dur_t[idx_inc] == '0;
    if (bus.abort) begin
      state_n = IDLE;
      idx_n = '0;
      rem_n = '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          if (dur_t[0] == '0) state_n = DONE;
          else begin
            state_n = RUN;
            idx_n = '0;
            rem_n = dur_t[0];
            clr = 1'b1;
          end
        end
        RUN: if (!last) rem_n = rem - DUR_W'(1);
        else if (!prog_end) begin
          idx_n = idx_inc;
          rem_n = dur_t[idx_inc];
        end else if (bus.loop_en) begin
          idx_n = '0;
          rem_n = dur_t[0];
        end else begin
          state_n = DONE;
          idx_n = '0;
        end
        default: state_n = IDLE;
      endcase
    end
    // the register is loaded with the value of the cycle being entered, ramping from the held value
    stp = {1'b0, step_t[idx_n]};
    diff = {amp_t[idx_n][DATA_W-1], amp_t[idx_n]} - {i_q[DATA_W-1], i_q};
    mag = diff[DATA_W] ? -diff : diff;
    i_ramp = (stp == '0 || mag <= stp) ? amp_t[idx_n] : diff[DATA_W] ? i_q - step_t[idx_n] : i_q + step_t[idx_n];
    i_n = state_n == RUN ? i_ramp : '0;
    for (int k = 0; k < NUM_CH; k++) begin
      armed_n[k] = armed[k];
      cnt_n[k] = cnt[k];
      if (clr) begin
        armed_n[k] = 1'b1;
        cnt_n[k] = '0;
      end else if (state == RUN) begin
        if (armed[k] && v_q[k] >= TH) begin
          armed_n[k] = 1'b0;
          cnt_n[k] = &cnt[k] ? cnt[k] : cnt[k] + CNT_W'(1);
        end else if (!armed[k] && v_q[k] < RE) armed_n[k] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      rem <= '0;
      i_q <= '0;
      armed <= '1;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt[k] <= '0;
        v_q[k] <= '0;
      end
    end else begin
      state <= state_n;
      idx <= idx_n;
      rem <= rem_n;
      i_q <= i_n;
      armed <= armed_n;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt[k] <= cnt_n[k];
        v_q[k] <= bus.v_in[k*DATA_W +: DATA_W];
      end
    end
  end
  // table holds no reset; writes are locked out only while a program runs
  always_ff @(posedge clk) begin
    if (bus.cfg_we && state != RUN) begin
      amp_t[bus.cfg_addr] <= bus.cfg_amp;
      dur_t[bus.cfg_addr] <= bus.cfg_dur;
      step_t[bus.cfg_addr] <= bus.cfg_step;
    end
  end
  assign bus.i_out = i_q;
  assign bus.phase_idx = idx;
  assign bus.busy = state == RUN;
  assign bus.phase_end = last;
  assign bus.done = state == DONE;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign bus.spike_cnt[g*CNT_W +: CNT_W] = cnt[g];
  end
endmodule
